// File: rtl/wb_stage_pkg.sv
// rtl/wb_stage_pkg.sv - shared load-type encoding and widths for the writeback stage
package wb_stage_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;

   typedef enum logic [2:0] {
      LD_NONE = 3'd0,
      LD_LB   = 3'd1,
      LD_LBU  = 3'd2,
      LD_LH   = 3'd3,
      LD_LHU  = 3'd4,
      LD_LW   = 3'd5,
      LD_LWL  = 3'd6,
      LD_LWR  = 3'd7
   } load_type_e;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load-data alignment, extension and LWL/LWR merge (LWLR_EN)
module load_align
   import wb_stage_pkg::*;
(
   input  load_type_e        load_type,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] alu_data,
   input  logic [DATA_W-1:0] mem_data,
`ifdef LWLR_EN
   input  logic [DATA_W-1:0] rt_old,
`endif
   output logic [DATA_W-1:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = mem_data[{addr_lo, 3'b000} +: 8];
   assign half_sel = addr_lo[1] ? mem_data[31:16] : mem_data[15:0];

   always_comb begin
      data = alu_data;
      case (load_type)
         LD_NONE: data = alu_data;
         LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
         LD_LBU:  data = {24'd0, byte_sel};
         LD_LH:   data = {{16{half_sel[15]}}, half_sel};
         LD_LHU:  data = {16'd0, half_sel};
`ifdef LWLR_EN
         LD_LW:   data = mem_data;
         LD_LWL: begin
            case (addr_lo)
               2'd0:    data = {mem_data[7:0],  rt_old[23:0]};
               2'd1:    data = {mem_data[15:0], rt_old[15:0]};
               2'd2:    data = {mem_data[23:0], rt_old[7:0]};
               default: data = mem_data;
            endcase
         end
         LD_LWR: begin
            case (addr_lo)
               2'd0:    data = mem_data;
               2'd1:    data = {rt_old[31:24], mem_data[31:8]};
               2'd2:    data = {rt_old[31:16], mem_data[31:16]};
               default: data = {rt_old[31:8],  mem_data[31:24]};
            endcase
         end
`else
         LD_LW, LD_LWL, LD_LWR: data = mem_data;
`endif
         default: data = alu_data;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - dual-slot writeback pipeline register with load-data hold and WAW resolution (LWLR_EN)
module wb_stage
   import wb_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              m_we1,
   input  logic              m_we2,
   input  logic [ADDR_W-1:0] m_waddr1,
   input  logic [ADDR_W-1:0] m_waddr2,
   input  logic [DATA_W-1:0] m_wdata1,
   input  logic [DATA_W-1:0] m_wdata2,
   input  logic [2:0]        m_load_type,
   input  logic [1:0]        m_addr_lo,
   input  logic [DATA_W-1:0] m_rt_old,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic              we1,
   output logic              we2,
   output logic [ADDR_W-1:0] waddr1,
   output logic [ADDR_W-1:0] waddr2,
   output logic [DATA_W-1:0] wdata1,
   output logic [DATA_W-1:0] wdata2
);

   logic              r_we1, r_we2;
   logic [ADDR_W-1:0] r_waddr1, r_waddr2;
   logic [DATA_W-1:0] r_wdata1, r_wdata2;
   load_type_e        r_load_type;
   logic [1:0]        r_addr_lo;
   logic [DATA_W-1:0] hold_data;
   logic              data_held;
   logic [DATA_W-1:0] load_rdata;
`ifdef LWLR_EN
   logic [DATA_W-1:0] r_rt_old;
`else
   logic              unused_rt_old;
   assign unused_rt_old = ^m_rt_old;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_we1       <= 1'b0;
         r_we2       <= 1'b0;
         r_waddr1    <= '0;
         r_waddr2    <= '0;
         r_wdata1    <= '0;
         r_wdata2    <= '0;
         r_load_type <= LD_NONE;
         r_addr_lo   <= '0;
         hold_data   <= '0;
         data_held   <= 1'b0;
`ifdef LWLR_EN
         r_rt_old    <= '0;
`endif
      end else if (flush_i) begin
         r_we1     <= 1'b0;
         r_we2     <= 1'b0;
         data_held <= 1'b0;
      end else if (stall_i) begin
         // The cache word is only valid in the load's first WB cycle; keep it for the stall.
         if (!data_held && r_load_type != LD_NONE) begin
            hold_data <= mem_rdata_i;
            data_held <= 1'b1;
         end
      end else begin
         r_we1       <= m_we1;
         r_we2       <= m_we2;
         r_waddr1    <= m_waddr1;
         r_waddr2    <= m_waddr2;
         r_wdata1    <= m_wdata1;
         r_wdata2    <= m_wdata2;
         r_load_type <= load_type_e'(m_load_type);
         r_addr_lo   <= m_addr_lo;
         data_held   <= 1'b0;
`ifdef LWLR_EN
         r_rt_old    <= m_rt_old;
`endif
      end
   end

   assign load_rdata = data_held ? hold_data : mem_rdata_i;

   load_align u_load_align (
      .load_type (r_load_type),
      .addr_lo   (r_addr_lo),
      .alu_data  (r_wdata1),
      .mem_data  (load_rdata),
`ifdef LWLR_EN
      .rt_old    (r_rt_old),
`endif
      .data      (wdata1)
   );

   // Slot 2 is the younger instruction, so it wins a same-register collision.
   assign we2    = r_we2 && (r_waddr2 != '0);
   assign we1    = r_we1 && (r_waddr1 != '0) && !(we2 && (r_waddr2 == r_waddr1));
   assign waddr1 = r_waddr1;
   assign waddr2 = r_waddr2;
   assign wdata2 = r_wdata2;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage (LWLR_EN selects expected LWL result)
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst, stall_i, flush_i;
   logic        m_we1, m_we2;
   logic [4:0]  m_waddr1, m_waddr2;
   logic [31:0] m_wdata1, m_wdata2;
   logic [2:0]  m_load_type;
   logic [1:0]  m_addr_lo;
   logic [31:0] m_rt_old, mem_rdata_i;
   logic        we1, we2;
   logic [4:0]  waddr1, waddr2;
   logic [31:0] wdata1, wdata2;

   typedef struct {
      logic        we1;
      logic        we2;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] d1;
      logic [31:0] d2;
      bit          full;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   tests_run = 0;
   int   tests_failed = 0;
   int   beat = 0;

   always #5 clk = ~clk;

   wb_stage dut (
      .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
      .m_we1(m_we1), .m_we2(m_we2), .m_waddr1(m_waddr1), .m_waddr2(m_waddr2),
      .m_wdata1(m_wdata1), .m_wdata2(m_wdata2), .m_load_type(m_load_type),
      .m_addr_lo(m_addr_lo), .m_rt_old(m_rt_old), .mem_rdata_i(mem_rdata_i),
      .we1(we1), .we2(we2), .waddr1(waddr1), .waddr2(waddr2),
      .wdata1(wdata1), .wdata2(wdata2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic e1, input logic e2, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [31:0] d1,
                               input logic [31:0] d2, input bit full);
      exp_t e;
      e.we1 = e1; e.we2 = e2; e.a1 = a1; e.a2 = a2; e.d1 = d1; e.d2 = d2; e.full = full;
      return e;
   endfunction

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         cur = sb.pop_front();
         beat++;
         check($sformatf("b%0d_we1", beat), {31'd0, we1}, {31'd0, cur.we1});
         check($sformatf("b%0d_we2", beat), {31'd0, we2}, {31'd0, cur.we2});
         if (cur.full) begin
            check($sformatf("b%0d_waddr1", beat), {27'd0, waddr1}, {27'd0, cur.a1});
            check($sformatf("b%0d_waddr2", beat), {27'd0, waddr2}, {27'd0, cur.a2});
            check($sformatf("b%0d_wdata1", beat), wdata1, cur.d1);
            check($sformatf("b%0d_wdata2", beat), wdata2, cur.d2);
         end
      end
   end

   task automatic slots(input logic e1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic e2, input logic [4:0] a2, input logic [31:0] d2,
                        input logic [2:0] lt, input logic [1:0] lo);
      m_we1 = e1; m_waddr1 = a1; m_wdata1 = d1;
      m_we2 = e2; m_waddr2 = a2; m_wdata2 = d2;
      m_load_type = lt; m_addr_lo = lo;
   endtask

   // Expectation describes the outputs after the coming edge; rdata is the cache word in that cycle.
   task automatic step(input exp_t e, input logic [31:0] rdata);
      sb.push_back(e);
      @(posedge clk);
      #1 mem_rdata_i = rdata;
   endtask

   initial begin
      rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
      m_rt_old = 32'hAABBCCDD; mem_rdata_i = 32'h0;
      slots(1, 5'd1, 32'h1, 1, 5'd2, 32'h2, 3'd0, 2'd0);
      step(mk(0, 0, 0, 0, 0, 0, 1), 32'h0);
      step(mk(0, 0, 0, 0, 0, 0, 1), 32'h0);
      rst = 1'b1;

      slots(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 3'd0, 2'd0);
      step(mk(1, 1, 3, 4, 32'h11, 32'h22, 1), 32'h0);

      slots(1, 5'd5, 32'hA, 1, 5'd5, 32'hB, 3'd0, 2'd0);
      step(mk(0, 1, 5, 5, 32'hA, 32'hB, 1), 32'h0);

      slots(1, 5'd0, 32'h5, 1, 5'd0, 32'h6, 3'd0, 2'd0);
      step(mk(0, 0, 0, 0, 32'h5, 32'h6, 1), 32'h0);

      slots(1, 5'd7, 32'h99, 0, 5'd0, 32'h0, 3'd1, 2'd2);
      step(mk(1, 0, 7, 0, 32'hFFFFFF80, 0, 1), 32'h1280FF00);
      slots(1, 5'd7, 32'h99, 0, 5'd0, 32'h0, 3'd2, 2'd2);
      step(mk(1, 0, 7, 0, 32'h00000080, 0, 1), 32'h1280FF00);
      slots(1, 5'd6, 32'h99, 0, 5'd0, 32'h0, 3'd3, 2'd2);
      step(mk(1, 0, 6, 0, 32'hFFFF8001, 0, 1), 32'h80011234);
      slots(1, 5'd6, 32'h99, 0, 5'd0, 32'h0, 3'd4, 2'd0);
      step(mk(1, 0, 6, 0, 32'h0000F234, 0, 1), 32'h0000F234);

`ifdef LWLR_EN
      slots(1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 3'd6, 2'd1);
      step(mk(1, 0, 9, 0, 32'h3344CCDD, 0, 1), 32'h11223344);
`else
      slots(1, 5'd9, 32'h99, 0, 5'd0, 32'h0, 3'd6, 2'd1);
      step(mk(1, 0, 9, 0, 32'h11223344, 0, 1), 32'h11223344);
`endif

      slots(1, 5'd8, 32'h99, 0, 5'd0, 32'h0, 3'd5, 2'd0);
      step(mk(1, 0, 8, 0, 32'hDEADBEEF, 0, 1), 32'hDEADBEEF);
      stall_i = 1'b1;
      slots(1, 5'd12, 32'h55, 1, 5'd13, 32'h66, 3'd0, 2'd0);
      for (int i = 0; i < 3; i++)
         step(mk(1, 0, 8, 0, 32'hDEADBEEF, 0, 1), 32'h0);
      stall_i = 1'b0;

      slots(1, 5'd9, 32'h99, 1, 5'd10, 32'hAA, 3'd0, 2'd0);
      step(mk(1, 1, 9, 10, 32'h99, 32'hAA, 1), 32'h0);
      flush_i = 1'b1; stall_i = 1'b1;
      step(mk(0, 0, 0, 0, 0, 0, 0), 32'h0);
      flush_i = 1'b0;
      step(mk(0, 0, 0, 0, 0, 0, 0), 32'h0);
      rst = 1'b0; flush_i = 1'b1;
      step(mk(0, 0, 0, 0, 0, 0, 1), 32'h0);
      rst = 1'b1; flush_i = 1'b0;
      step(mk(0, 0, 0, 0, 0, 0, 1), 32'h0);
      stall_i = 1'b0;
      slots(1, 5'd3, 32'h33, 0, 5'd0, 32'h0, 3'd0, 2'd0);
      step(mk(1, 0, 3, 0, 32'h33, 0, 1), 32'h0);

      @(negedge clk);
      #2;
      check("sb_drain", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
